tap_ir_datapath: RTL and testbench
==================================

TAP_IR_DATAPATH -- requirements
Module: tap_ir_datapath

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h1076_5003, 32-bit device identification word; bit 0 SHALL be 1.
REQ-002 Parameter IR_RESET_BYPASS, default 4'b1111, BYPASS opcode.
REQ-003 clock  input  1  test clock (TCK); all registers rise-edge except tdo/tdo_oe (fall-edge).
REQ-004 reset  input  1  asynchronous, active-high (TRST).
REQ-005 tdi  input  1  serial test data in.
REQ-006 select  input  1  1 = IR path to tdo, 0 = DR path.
REQ-007 capture_ir, shift_ir, update_ir  input  1 each  IR phase enables from TAP controller.
REQ-008 capture_dr, shift_dr, update_dr  input  1 each  DR phase enables from TAP controller.
REQ-009 bsr_tdo  input  1  serial out of external boundary-scan chain.
REQ-010 tdo  output  1  serial test data out.
REQ-011 tdo_oe  output  1  tdo drive enable.
REQ-012 ir_current  output  4  active (updated) instruction.
REQ-013 extest, sample  output  1 each  decoded mode flags to boundary cells.
REQ-014 bsr_capture, bsr_shift, bsr_update  output  1 each  DR enables gated to boundary chain.

Function
REQ-015 Opcodes: EXTEST 4'b0000, SAMPLE 4'b0001, IDCODE 4'b0010, BYPASS 4'b1111; every other opcode SHALL decode as BYPASS.
REQ-016 IR shift register (4 bit): capture_ir loads 4'b0001; shift_ir shifts right, tdi into bit 3, bit 0 is serial out.
REQ-017 Capture SHALL take priority over shift when both asserted in the same cycle; same for DR.
REQ-018 update_ir copies the shift register into ir_current on the same rising edge; ir_current otherwise holds, including during shift_ir.
REQ-019 Bypass register (1 bit): capture_dr loads 0, shift_dr loads tdi, when BYPASS decoded.
REQ-020 IDCODE register (32 bit): capture_dr loads IDCODE_VALUE, shift_dr shifts right with tdi into bit 31, when IDCODE decoded.
REQ-021 Non-selected DRs SHALL hold value during capture_dr/shift_dr.
REQ-022 bsr_capture/bsr_shift/bsr_update = capture_dr/shift_dr/update_dr AND (EXTEST or SAMPLE decoded), combinational; 0 otherwise.
REQ-023 extest = (ir_current==EXTEST); sample = (ir_current==SAMPLE); combinational from ir_current.
REQ-024 Serial source mux: select=1 -> IR bit 0; else EXTEST/SAMPLE -> bsr_tdo, IDCODE -> IDCODE bit 0, BYPASS -> bypass bit.
REQ-025 tdo SHALL register the mux output on the falling clock edge when shift_ir or shift_dr is high, otherwise hold; tdo_oe registers (shift_ir | shift_dr) on the falling edge.
REQ-026 Latency: first bit appears on tdo half a clock after the first rising edge with shift asserted; N shift cycles move N bits.
REQ-027 Simultaneous IR and DR enables are illegal input; select SHALL then determine tdo source and both paths act on their own enables.

Reset
REQ-028 reset asserted SHALL immediately force: IR shift reg 4'b0001, ir_current to reset instruction, bypass 0, IDCODE reg IDCODE_VALUE, tdo 0, tdo_oe 0.
REQ-029 Reset mid-shift SHALL discard partial data; first rising edge after release uses normal rules.

Configuration
REQ-030 Macro TAP_IDCODE_EN: defined -> IDCODE register present, reset instruction IDCODE (4'b0010).
REQ-031 TAP_IDCODE_EN undefined -> no IDCODE register, opcode 4'b0010 decodes as BYPASS, reset instruction BYPASS (4'b1111); IDCODE_VALUE ignored.

Verification
REQ-032 Reset, then capture_dr + 32 shift_dr with TAP_IDCODE_EN -> tdo serial sequence equals 32'h1076_5003 LSB first.
REQ-033 capture_ir then 4 shift_ir with tdi 1,1,1,1 -> tdo 1,0,0,0; after update_ir ir_current=4'b1111.
REQ-034 Load BYPASS, capture_dr, shift tdi pattern 1,0,1,1 -> tdo 0,1,0,1 (one-cycle delay).
REQ-035 Load EXTEST -> extest=1, bsr_shift follows shift_dr, tdo follows bsr_tdo; load 4'b0110 -> behaves as BYPASS, extest=sample=0.
REQ-036 Assert reset after 2 of 4 shift_ir cycles -> ir_current = reset instruction, tdo=0, tdo_oe=0 immediately; without TAP_IDCODE_EN reset gives ir_current=4'b1111.

Source files
------------

// File: rtl/tap_ir_datapath.sv
// JTAG TAP datapath: 4-bit instruction register, bypass/IDCODE data registers and falling-edge TDO.
// Define TAP_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module tap_ir_datapath #(
    parameter logic [31:0] IDCODE_VALUE    = 32'h1076_5003,
    parameter logic [3:0]  IR_RESET_BYPASS = 4'b1111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tdi,
    input  logic       select,
    input  logic       capture_ir,
    input  logic       shift_ir,
    input  logic       update_ir,
    input  logic       capture_dr,
    input  logic       shift_dr,
    input  logic       update_dr,
    input  logic       bsr_tdo,
    output logic       tdo,
    output logic       tdo_oe,
    output logic [3:0] ir_current,
    output logic       extest,
    output logic       sample,
    output logic       bsr_capture,
    output logic       bsr_shift,
    output logic       bsr_update
);

    localparam logic [3:0] OP_EXTEST  = 4'b0000;
    localparam logic [3:0] OP_SAMPLE  = 4'b0001;
    localparam logic [3:0] IR_CAPTURE = 4'b0001;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] OP_IDCODE      = 4'b0010;
    localparam logic [3:0] IR_RESET_VALUE = OP_IDCODE;
`else
    localparam logic [3:0] IR_RESET_VALUE = IR_RESET_BYPASS;
`endif

    typedef enum logic [1:0] {
        INSN_EXTEST,
        INSN_SAMPLE,
        INSN_IDCODE,
        INSN_BYPASS
    } insn_t;

    // A device identification word must have its LSB set so it is distinguishable from bypass.
    if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
        $error("IDCODE_VALUE bit 0 must be 1");
    end

    logic [3:0] ir_shift;
    logic       bypass_reg;
    logic       tdo_next;
    logic       bsr_selected;
    insn_t      insn;

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_shift   <= IR_CAPTURE;
            ir_current <= IR_RESET_VALUE;
        end else begin
            if (capture_ir) begin
                ir_shift <= IR_CAPTURE;
            end else if (shift_ir) begin
                ir_shift <= {tdi, ir_shift[3:1]};
            end
            if (update_ir) begin
                ir_current <= ir_shift;
            end
        end
    end

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        insn = INSN_BYPASS;
        case (ir_current)
            OP_EXTEST: insn = INSN_EXTEST;
            OP_SAMPLE: insn = INSN_SAMPLE;
`ifdef TAP_IDCODE_EN
            OP_IDCODE: insn = INSN_IDCODE;
`endif
            default:   insn = INSN_BYPASS;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bypass_reg <= 1'b0;
        end else if (insn == INSN_BYPASS) begin
            if (capture_dr) begin
                bypass_reg <= 1'b0;
            end else if (shift_dr) begin
                bypass_reg <= tdi;
            end
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] idcode_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idcode_reg <= IDCODE_VALUE;
        end else if (insn == INSN_IDCODE) begin
            if (capture_dr) begin
                idcode_reg <= IDCODE_VALUE;
            end else if (shift_dr) begin
                idcode_reg <= {tdi, idcode_reg[31:1]};
            end
        end
    end
`endif

    assign extest       = (ir_current == OP_EXTEST);
    assign sample       = (ir_current == OP_SAMPLE);
    assign bsr_selected = (insn == INSN_EXTEST) || (insn == INSN_SAMPLE);
    assign bsr_capture  = capture_dr & bsr_selected;
    assign bsr_shift    = shift_dr & bsr_selected;
    assign bsr_update   = update_dr & bsr_selected;

    always_comb begin
        tdo_next = bypass_reg;
        if (select) begin
            tdo_next = ir_shift[0];
        end else begin
            case (insn)
                INSN_EXTEST, INSN_SAMPLE: tdo_next = bsr_tdo;
`ifdef TAP_IDCODE_EN
                INSN_IDCODE:              tdo_next = idcode_reg[0];
`endif
                default:                  tdo_next = bypass_reg;
            endcase
        end
    end

    // TDO changes on the falling edge so the downstream device samples it stably on the next rising edge.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo_oe <= shift_ir | shift_dr;
            if (shift_ir || shift_dr) begin
                tdo <= tdo_next;
            end
        end
    end

endmodule

// File: tb/tb_tap_ir_datapath.sv
// Self-checking bench for tap_ir_datapath; expected TDO streams come from a FIFO model
// (captured bits leave first, followed by the TDI bits in the order they were shifted in).
module tb_tap_ir_datapath;

    localparam logic [31:0] IDCODE = 32'h1076_5003;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'b0010;
`else
    localparam logic [3:0] RST_IR = 4'b1111;
`endif

    logic       clock;
    logic       reset;
    logic       tdi;
    logic       select;
    logic       capture_ir;
    logic       shift_ir;
    logic       update_ir;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       bsr_tdo;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] ir_current;
    logic       extest;
    logic       sample;
    logic       bsr_capture;
    logic       bsr_shift;
    logic       bsr_update;

    int tests;
    int fails;

    tap_ir_datapath dut (
        .clock      (clock),
        .reset      (reset),
        .tdi        (tdi),
        .select     (select),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .bsr_tdo    (bsr_tdo),
        .tdo        (tdo),
        .tdo_oe     (tdo_oe),
        .ir_current (ir_current),
        .extest     (extest),
        .sample     (sample),
        .bsr_capture(bsr_capture),
        .bsr_shift  (bsr_shift),
        .bsr_update (bsr_update)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic to_fall();
        @(negedge clock);
        #1;
    endtask

    task automatic to_rise();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        tdi        = 1'b0;
    endtask

    // Capture an instruction register, shift op in LSB first, update; checks TDO and decode flags.
    task automatic load_ir(input logic [3:0] op);
        logic exp_bit;
        idle();
        capture_ir = 1'b1;
        to_fall();
        to_rise();
        capture_ir = 1'b0;
        shift_ir   = 1'b1;
        select     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdi = op[i];
            to_fall();
            exp_bit = (i == 0);
            tests++;
            if (tdo !== exp_bit) begin
                fails++;
                $display("FAIL ir_shift_out[%0d] op=%b: got %b expected %b", i, op, tdo, exp_bit);
            end
            to_rise();
        end
        shift_ir  = 1'b0;
        update_ir = 1'b1;
        to_fall();
        to_rise();
        update_ir = 1'b0;
        tests++;
        if (ir_current !== op) begin
            fails++;
            $display("FAIL ir_update: got %b expected %b", ir_current, op);
        end
        tests++;
        if ({extest, sample} !== {op == 4'b0000, op == 4'b0001}) begin
            fails++;
            $display("FAIL mode_flags op=%b: got %b expected %b", op, {extest, sample},
                     {op == 4'b0000, op == 4'b0001});
        end
    endtask

    // Capture a data register of the given width, then shift n bits; tdo is compared with a FIFO model.
    task automatic run_dr_shift(input logic [31:0] cap, input int width, input int n,
                                input logic [39:0] bits, input string name);
        logic q[$];
        logic exp_bit;
        idle();
        select     = 1'b0;
        capture_dr = 1'b1;
        to_fall();
        to_rise();
        capture_dr = 1'b0;
        q.delete();
        for (int i = 0; i < width; i++) q.push_back(cap[i]);
        shift_dr = 1'b1;
        for (int k = 0; k < n; k++) begin
            tdi     = bits[k];
            exp_bit = q.pop_front();
            q.push_back(tdi);
            to_fall();
            tests++;
            if (tdo !== exp_bit || tdo_oe !== 1'b1) begin
                fails++;
                $display("FAIL %s[%0d]: got tdo=%b oe=%b expected tdo=%b oe=1", name, k, tdo, tdo_oe, exp_bit);
            end
            to_rise();
        end
        shift_dr = 1'b0;
        to_fall();
        tests++;
        if (tdo_oe !== 1'b0) begin
            fails++;
            $display("FAIL %s_oe_release: got %b expected 0", name, tdo_oe);
        end
        to_rise();
    endtask

    task automatic test_reset();
        tests++;
        if (ir_current !== RST_IR) begin
            fails++;
            $display("FAIL reset_ir: got %b expected %b", ir_current, RST_IR);
        end
        tests++;
        if ({tdo, tdo_oe} !== 2'b00) begin
            fails++;
            $display("FAIL reset_tdo: got %b expected 00", {tdo, tdo_oe});
        end
        tests++;
        if ({extest, sample, bsr_capture, bsr_shift, bsr_update} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {extest, sample, bsr_capture, bsr_shift, bsr_update});
        end
        to_rise();
        reset = 1'b0;
`ifdef TAP_IDCODE_EN
        run_dr_shift(IDCODE, 32, 36, {$urandom, $urandom}, "idcode_after_reset");
`else
        run_dr_shift(32'h0, 1, 8, {$urandom, $urandom}, "bypass_after_reset");
`endif
    endtask

    task automatic test_ir_shift();
        load_ir(4'b1111);
    endtask

    task automatic test_bypass();
        load_ir(4'b1111);
        run_dr_shift(32'h0, 1, 4, 40'hD, "bypass_1011");
        run_dr_shift(32'h0, 1, 12, {$urandom, $urandom}, "bypass_random");
    endtask

    task automatic test_idcode_opcode();
        load_ir(4'b0010);
`ifdef TAP_IDCODE_EN
        run_dr_shift(IDCODE, 32, 34, {$urandom, $urandom}, "idcode_opcode");
`else
        run_dr_shift(32'h0, 1, 8, {$urandom, $urandom}, "idcode_as_bypass");
`endif
    endtask

    task automatic test_boundary();
        logic exp_tdo;
        load_ir(4'b1111);
        run_dr_shift(32'h0, 1, 6, 40'h20, "bypass_preload");
        load_ir(4'b0000);
        select     = 1'b0;
        capture_dr = 1'b1;
        to_fall();
        tests++;
        if ({bsr_capture, bsr_shift} !== 2'b10) begin
            fails++;
            $display("FAIL extest_capture: got %b expected 10", {bsr_capture, bsr_shift});
        end
        to_rise();
        capture_dr = 1'b0;
        exp_tdo = 1'b0;
        for (int k = 0; k < 16; k++) begin
            shift_dr = (k == 0) ? 1'b1 : 1'($urandom);
            bsr_tdo  = 1'($urandom);
            tdi      = (k == 15) ? 1'b0 : 1'($urandom);
            if (shift_dr) exp_tdo = bsr_tdo;
            to_fall();
            tests++;
            if (tdo !== exp_tdo || bsr_shift !== shift_dr || tdo_oe !== shift_dr) begin
                fails++;
                $display("FAIL extest_shift[%0d]: got tdo=%b bsr_shift=%b oe=%b expected %b %b %b",
                         k, tdo, bsr_shift, tdo_oe, exp_tdo, shift_dr, shift_dr);
            end
            to_rise();
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        to_fall();
        tests++;
        if (bsr_update !== 1'b1) begin
            fails++;
            $display("FAIL extest_update: got %b expected 1", bsr_update);
        end
        to_rise();
        update_dr = 1'b0;
        load_ir(4'b1111);
        select   = 1'b0;
        shift_dr = 1'b1;
        to_fall();
        tests++;
        if (tdo !== 1'b1) begin
            fails++;
            $display("FAIL bypass_hold: got %b expected 1", tdo);
        end
        to_rise();
        idle();
        load_ir(4'b0001);
        capture_dr = 1'b1;
        to_fall();
        tests++;
        if (bsr_capture !== 1'b1) begin
            fails++;
            $display("FAIL sample_capture: got %b expected 1", bsr_capture);
        end
        to_rise();
        idle();
        load_ir(4'b0110);
        shift_dr = 1'b1;
        to_fall();
        tests++;
        if (bsr_shift !== 1'b0) begin
            fails++;
            $display("FAIL unused_op_bsr_shift: got %b expected 0", bsr_shift);
        end
        to_rise();
        run_dr_shift(32'h0, 1, 8, {$urandom, $urandom}, "bypass_0110");
    endtask

    task automatic test_random_ir();
        logic [3:0] op;
        for (int r = 0; r < 6; r++) begin
            op = 4'($urandom);
            load_ir(op);
`ifdef TAP_IDCODE_EN
            if (op == 4'b0010) begin
                run_dr_shift(IDCODE, 32, 33, {$urandom, $urandom}, "random_idcode");
                continue;
            end
`endif
            if (op != 4'b0000 && op != 4'b0001)
                run_dr_shift(32'h0, 1, 4 + int'($urandom_range(6, 0)), {$urandom, $urandom}, "random_bypass");
        end
    endtask

    task automatic test_priority();
        idle();
        select   = 1'b1;
        shift_ir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_fall();
            to_rise();
        end
        capture_ir = 1'b1;
        to_fall();
        to_rise();
        idle();
        update_ir = 1'b1;
        to_fall();
        to_rise();
        update_ir = 1'b0;
        tests++;
        if (ir_current !== 4'b0001 || sample !== 1'b1) begin
            fails++;
            $display("FAIL ir_capture_priority: got %b sample=%b expected 0001 sample=1", ir_current, sample);
        end
        load_ir(4'b1111);
        select   = 1'b0;
        shift_dr = 1'b1;
        tdi      = 1'b1;
        to_fall();
        to_rise();
        capture_dr = 1'b1;
        to_fall();
        to_rise();
        capture_dr = 1'b0;
        to_fall();
        tests++;
        if (tdo !== 1'b0) begin
            fails++;
            $display("FAIL dr_capture_priority: got %b expected 0", tdo);
        end
        to_rise();
        idle();
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] op;
        logic       exp_bit;
        load_ir(4'b0000);
        select   = 1'b0;
        bsr_tdo  = 1'b1;
        shift_ir = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tdi = 1'b1;
            to_fall();
            tests++;
            if (tdo !== 1'b1 || tdo_oe !== 1'b1) begin
                fails++;
                $display("FAIL pre_reset_tdo[%0d]: got %b%b expected 11", i, tdo, tdo_oe);
            end
            to_rise();
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (ir_current !== RST_IR || tdo !== 1'b0 || tdo_oe !== 1'b0) begin
            fails++;
            $display("FAIL mid_shift_reset: got ir=%b tdo=%b oe=%b expected ir=%b tdo=0 oe=0",
                     ir_current, tdo, tdo_oe, RST_IR);
        end
        idle();
        bsr_tdo = 1'b0;
        to_fall();
        to_rise();
        reset    = 1'b0;
        op       = 4'b0110;
        select   = 1'b1;
        shift_ir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdi = op[i];
            to_fall();
            exp_bit = (i == 0);
            tests++;
            if (tdo !== exp_bit) begin
                fails++;
                $display("FAIL post_reset_ir_out[%0d]: got %b expected %b", i, tdo, exp_bit);
            end
            to_rise();
        end
        shift_ir  = 1'b0;
        update_ir = 1'b1;
        to_fall();
        to_rise();
        update_ir = 1'b0;
        tests++;
        if (ir_current !== op) begin
            fails++;
            $display("FAIL post_reset_update: got %b expected %b", ir_current, op);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        select  = 1'b0;
        bsr_tdo = 1'b0;
        idle();
        #1;
        test_reset();
        test_ir_shift();
        test_bypass();
        test_idcode_opcode();
        test_boundary();
        test_random_ir();
        test_priority();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
